// File: rtl/std_pipe_skid.sv
// std_pipe_skid: fully registered 2-entry valid/ready skid slice.
// Every output decodes from flops only, so data, valid and ready paths are all cut.
module std_pipe_skid #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          FLUSH_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  flush_eff;
    logic                  in_hs;
    logic                  out_hs;
    logic                  main_ld_in;
    logic                  main_ld_skid;
    logic                  skid_ld;

    assign flush_eff = FLUSH_EN & flush;
    assign m_valid   = (state_q != ST_EMPTY);
    assign s_ready   = (state_q != ST_FULL);
    assign m_data    = main_q;
    // State encoding equals occupancy, so count needs no extra decode.
    assign count     = state_q;
    assign in_hs     = s_valid & s_ready;
    assign out_hs    = m_valid & m_ready;

    always_comb begin
        state_d      = state_q;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        if (flush_eff) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_hs) begin
                        state_d    = ST_BUSY;
                        main_ld_in = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (in_hs && out_hs) begin
                        main_ld_in = 1'b1;
                    end else if (in_hs) begin
                        state_d = ST_FULL;
                        skid_ld = 1'b1;
                    end else if (out_hs) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_hs) begin
                        state_d      = ST_BUSY;
                        main_ld_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (main_ld_in) begin
                main_q <= s_data;
            end else if (main_ld_skid) begin
                main_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= s_data;
            end
        end
    end

    // Upstream must hold its payload while stalled; a flush releases that obligation.
    property p_upstream_hold;
        @(posedge clk) disable iff (!aresetn)
            (s_valid && !s_ready && !flush_eff) |=> $stable(s_data);
    endproperty
    a_upstream_hold: assert property (p_upstream_hold);

endmodule
